// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
//
// Handshakes:
//  - imem_req/imem_ack: imem_req is a valid that stays high with a stable
//    imem_addr until a cycle with imem_ack=1. An ack can come in the same
//    cycle as the request, and memory ignores anything while imem_req=0.
//  - decode bundle: valid_out marks a real instruction and freeze=1 means
//    decode is not taking it. The word in instruction/PC_out is consumed
//    on an edge with valid_out=1 and freeze=0.
//  - branch_taken is a one-cycle redirect pulse. It beats freeze and ack.
interface if_fetch_unit_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PC_out;
  logic        valid_out;
  logic [1:0]  state_dbg;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, instruction, PC_out, valid_out, state_dbg
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instruction, PC_out, valid_out, state_dbg
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It keeps the PC, fetches words over req/ack and
// hands a registered instruction/PC_out/valid_out bundle to decode. A
// one-entry skid buffer catches a word that returns while decode is frozen.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);

  // REQ : a request is outstanding at pc.
  // DROP: a redirect arrived before the ack. The access at the old pc still
  //       has to finish, and its word is thrown away.
  // HOLD: a fetched word is parked in the skid buffer while decode is frozen.
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;

  logic [31:0] pc_next_seq;
  logic        out_free;
  logic        accept;

  assign pc_next_seq = pc + PC_STEP;
  // The output registers can take a new word unless decode holds a real one.
  assign out_free    = !bus.freeze || !valid_q;
  // A word is useful only when it is acked in REQ with no redirect in that cycle.
  assign accept      = (state == ST_REQ) && bus.imem_ack && !bus.branch_taken;

  // Keep the request low while reset is held, so an access cut off by reset
  // is dropped and no ack is taken until reset is released.
  assign bus.imem_req    = !rst && (state != ST_HOLD);
  assign bus.imem_addr   = pc;
  assign bus.instruction = instr_q;
  assign bus.PC_out      = pc_out_q;
  assign bus.valid_out   = valid_q;
  assign bus.state_dbg   = state;

  // FSM, program counter, redirect target and skid buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      target     <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (bus.branch_taken) begin
            if (bus.imem_ack) begin
              pc <= bus.branch_addr;
            end else begin
              target <= bus.branch_addr;
              state  <= ST_DROP;
            end
          end else if (bus.imem_ack) begin
            pc <= pc_next_seq;
            if (!out_free) begin
              skid_instr <= bus.imem_rdata;
              skid_pc    <= pc_next_seq;
              state      <= ST_HOLD;
            end
          end
        end
        ST_DROP: begin
          if (bus.branch_taken) begin
            if (bus.imem_ack) begin
              pc    <= bus.branch_addr;
              state <= ST_REQ;
            end else begin
              target <= bus.branch_addr;
            end
          end else if (bus.imem_ack) begin
            pc    <= target;
            state <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (bus.branch_taken) begin
            skid_instr <= '0;
            skid_pc    <= '0;
            pc         <= bus.branch_addr;
            state      <= ST_REQ;
          end else if (!bus.freeze) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // Output bundle to decode: flush on redirect, hold on freeze, otherwise
  // load the skid word, a fresh word, or a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus.branch_taken) begin
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else if (state == ST_HOLD) begin
      if (!bus.freeze) begin
        instr_q  <= skid_instr;
        pc_out_q <= skid_pc;
        valid_q  <= 1'b1;
      end
    end else if (accept && out_free) begin
      instr_q  <= bus.imem_rdata;
      pc_out_q <= pc_next_seq;
      valid_q  <= 1'b1;
    end else if (!bus.freeze) begin
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end
  end

endmodule
